// File: rtl/halfbridge_pkg.sv
// Shared types and constants for the half-bridge duty sequencer.
package halfbridge_pkg;
  localparam int DUTY_W    = 10;
  localparam int D_MAX_DEF = 1023;
  localparam int STEP_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_RUN,
    ST_FAULT
  } hb_state_t;
endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer with rising-edge detect; emits a registered one-cycle pulse
// per rising edge of an asynchronous input.
module pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);
  logic sync0_reg, sync1_reg, prev_reg, pulse_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0_reg <= 1'b0;
      sync1_reg <= 1'b0;
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync0_reg <= async_in;
      sync1_reg <= sync0_reg;
      prev_reg  <= sync1_reg;
      pulse_reg <= sync1_reg & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;
endmodule

// File: rtl/halfbridge_ramp_ctrl.sv
// Duty-cycle sequencer: slews d_out toward the target by at most STEP per interrupt tick.
// at_target is combinational from d_out and the effective target (no lag).
module halfbridge_ramp_ctrl
  import halfbridge_pkg::*;
#(
  parameter int D_MAX = D_MAX_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_int,
  input  logic              en,
  input  logic [DUTY_W-1:0] tgt,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic              fault,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] d_out,
  output logic              ce_out,
  output logic              at_target,
  output logic              fault_latched
);
  localparam logic [DUTY_W-1:0]        DMAX_V = DUTY_W'(D_MAX);
  localparam logic [DUTY_W-1:0]        STEP_V = DUTY_W'(STEP);
  localparam logic signed [DUTY_W:0]   STEP_S = (DUTY_W + 1)'(STEP);

  hb_state_t          state_reg;
  logic [DUTY_W-1:0]  tgt_reg;
  logic [DUTY_W-1:0]  d_reg;
  logic [DUTY_W-1:0]  d_next;
  logic [DUTY_W-1:0]  eff_tgt;
  logic [DUTY_W-1:0]  tgt_clamped;
  logic signed [DUTY_W:0] diff;
  logic               ce_reg;
  logic               fault_reg;
  logic               tick;
  logic               accept;

  pulse_sync u_tick_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (clk_int),
    .pulse    (tick)
  );

  assign eff_tgt     = en ? tgt_reg : '0;
  assign tgt_clamped = (tgt > DMAX_V) ? DMAX_V : tgt;
  assign tgt_ready   = rst_n && (state_reg != ST_FAULT);
  assign accept      = tgt_valid && tgt_ready;
  assign diff        = $signed({1'b0, eff_tgt}) - $signed({1'b0, d_reg});

  // Moving toward eff_tgt (itself within 0..D_MAX) can never wrap.
  always_comb begin
    d_next = eff_tgt;
    if (diff > STEP_S) begin
      d_next = d_reg + STEP_V;
    end else if (diff < -STEP_S) begin
      d_next = d_reg - STEP_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      d_reg     <= '0;
      ce_reg    <= 1'b0;
      tgt_reg   <= '0;
      fault_reg <= 1'b0;
    end else if (fault) begin
      state_reg <= ST_FAULT;
      d_reg     <= '0;
      ce_reg    <= 1'b0;
      tgt_reg   <= '0;
      fault_reg <= 1'b1;
    end else begin
      // The slew below still sees the old tgt_reg on an accepting edge.
      if (accept) begin
        tgt_reg <= tgt_clamped;
      end
      case (state_reg)
        ST_IDLE: begin
          d_reg  <= '0;
          ce_reg <= 1'b0;
          if (en && (tgt_reg != '0)) begin
            state_reg <= ST_RAMP;
            ce_reg    <= 1'b1;
          end
        end
        ST_RAMP: begin
          if (tick) begin
            d_reg <= d_next;
          end
          if (d_reg == eff_tgt) begin
            if (en) begin
              state_reg <= ST_RUN;
            end else begin
              state_reg <= ST_IDLE;
              ce_reg    <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (tick) begin
            d_reg <= d_next;
          end
          if (d_reg != eff_tgt) begin
            state_reg <= ST_RAMP;
          end
        end
        ST_FAULT: begin
          if (fault_clr && !en) begin
            state_reg <= ST_IDLE;
            fault_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign d_out         = d_reg;
  assign ce_out        = ce_reg;
  assign fault_latched = fault_reg;
  assign at_target     = (d_reg == eff_tgt);
endmodule

// File: tb/tb_halfbridge_ramp_ctrl.sv
// Directed and randomized checks of halfbridge_ramp_ctrl against a behavioural slew model.
module tb_halfbridge_ramp_ctrl;
  localparam int DMAX = 600;
  localparam int STP  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_int = 1'b0;
  logic       en = 1'b0;
  logic [9:0] tgt = '0;
  logic       tgt_valid = 1'b0;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic       tgt_ready;
  logic [9:0] d_out;
  logic       ce_out;
  logic       at_target;
  logic       fault_latched;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_d   = 0;
  int tgt_m   = 0;

  always #5 clk = ~clk;

  halfbridge_ramp_ctrl #(.D_MAX(DMAX), .STEP(STP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_int       (clk_int),
    .en            (en),
    .tgt           (tgt),
    .tgt_valid     (tgt_valid),
    .tgt_ready     (tgt_ready),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .d_out         (d_out),
    .ce_out        (ce_out),
    .at_target     (at_target),
    .fault_latched (fault_latched)
  );

  // Applied duty after one tick: closes the gap in one go if it is at most STP.
  function automatic int toward(input int cur, input int target);
    if (target >= cur) return (target - cur > STP) ? cur + STP : target;
    return (cur - target > STP) ? cur - STP : target;
  endfunction

  function automatic int clamp(input int t);
    return (t > DMAX) ? DMAX : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
    $display("[TB] %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic handshake(input int t);
    @(negedge clk);
    tgt       = 10'(t);
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  // One interrupt period; d_out has settled by the time this returns.
  task automatic pulse();
    @(negedge clk);
    clk_int = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    clk_int = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic ramp(input int n, input int eff, input string tag);
    for (int i = 0; i < n; i++) begin
      pulse();
      exp_d = toward(exp_d, eff);
      chk(tag, d_out, exp_d);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_d_out", d_out, 0);
    chk("rst_ce", ce_out, 0);
    chk("rst_at_target", at_target, 1);
    chk("rst_fault_latched", fault_latched, 0);
    chk("rst_tgt_ready", tgt_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tgt_ready", tgt_ready, 1);

    // Soft-start to 100
    en = 1'b1;
    handshake(100);
    @(negedge clk);
    chk("start_ce", ce_out, 1);
    chk("start_d_out", d_out, 0);
    exp_d = 0;
    for (int i = 0; i < 13; i++) begin
      pulse();
      exp_d = toward(exp_d, 100);
      chk("softstart_d", d_out, exp_d);
      chk("softstart_at", at_target, (exp_d == 100) ? 1 : 0);
    end
    chk("softstart_ce", ce_out, 1);

    // Clamp (1000 -> 600), then reverse mid-ramp toward 40
    handshake(1000);
    ramp(5, clamp(1000), "clamp_up_d");
    handshake(40);
    ramp(13, 40, "retarget_down_d");
    chk("retarget_at", at_target, 1);

    // Back to 100, then soft-stop
    handshake(100);
    ramp(8, 100, "reup_d");
    @(negedge clk);
    en = 1'b0;
    ramp(12, 0, "softstop_d");
    chk("softstop_ce_mid", ce_out, 1);
    ramp(1, 0, "softstop_d");
    chk("softstop_ce_off", ce_out, 0);

    // Fault mid-ramp at 48
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    exp_d = 0;
    ramp(6, 100, "fault_pre_d");
    @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    chk("fault_d_out", d_out, 0);
    chk("fault_ce", ce_out, 0);
    chk("fault_tgt_ready", tgt_ready, 0);
    chk("fault_latched", fault_latched, 1);
    clr_pulse();
    chk("clr_with_fault", fault_latched, 1);
    fault = 1'b0;
    clr_pulse();
    chk("clr_with_en", fault_latched, 1);
    en = 1'b0;
    clr_pulse();
    chk("clr_ok_latched", fault_latched, 0);
    chk("clr_ok_ready", tgt_ready, 1);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("tgt_cleared_ce", ce_out, 0);

    // Handshake coincident with the tick: slew uses the old target
    handshake(200);
    @(negedge clk);
    exp_d = 0;
    ramp(3, 200, "coinc_pre_d");
    @(negedge clk);
    clk_int = 1'b1;
    repeat (3) @(negedge clk);
    tgt       = 10'd16;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    clk_int   = 1'b0;
    repeat (3) @(negedge clk);
    exp_d = toward(exp_d, 200);
    chk("coinc_old_tgt_d", d_out, exp_d);
    ramp(1, 16, "coinc_new_tgt_d");

    // Reset mid-ramp
    handshake(300);
    ramp(2, 300, "prereset_d");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_d_out", d_out, 0);
    chk("midrst_ce", ce_out, 0);
    chk("midrst_at_target", at_target, 1);
    chk("midrst_fault_latched", fault_latched, 0);
    chk("midrst_tgt_ready", tgt_ready, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("postrst_at_target", at_target, 1);
    chk("postrst_ce", ce_out, 0);

    // Asynchronous clk_int with random phase and period, random targets
    exp_d = 0;
    tgt_m = 0;
    for (int p = 0; p < 1000; p++) begin
      if (exp_d == tgt_m) begin
        int t;
        t = int'($urandom_range(0, 1023));
        handshake(t);
        tgt_m = clamp(t);
      end
      #($urandom_range(0, 9));
      clk_int = 1'b1;
      #(10 * $urandom_range(4, 7) + $urandom_range(0, 9));
      clk_int = 1'b0;
      #(10 * $urandom_range(4, 7) + $urandom_range(0, 9));
      @(negedge clk);
      exp_d = toward(exp_d, tgt_m);
      chk("async_d", d_out, exp_d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
